// File: rtl/seq_alu_pkg.sv
// Shared encodings for the sequential ALU: opcode and FSM state enums.
package seq_alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_REM = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_e;

    function automatic logic is_iterative(input op_e op);
        return (op == OP_MUL) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Operation/result handshake bundle for seq_alu.
// The quot signal exists only when SEQ_ALU_QUOT_EN is defined.
interface seq_alu_if
    import seq_alu_pkg::*;
#(
    parameter int W = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic signed [W-1:0]   a;
    logic signed [W-1:0]   b;
    op_e                   op;
    logic                  out_valid;
    logic                  out_ready;
    logic signed [2*W-1:0] r;
    logic                  err;
`ifdef SEQ_ALU_QUOT_EN
    logic signed [W:0]     quot;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, r, err, quot
    );
    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, r, err, quot
    );
`else
    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, r, err
    );
    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, r, err
    );
`endif
endinterface

// File: rtl/seq_alu_div.sv
// Restoring magnitude divider: one quotient bit per cycle, W cycles per start.
// rem/quo/done are the values produced by the iteration completing on this edge.
module seq_alu_div #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         done,
`ifdef SEQ_ALU_QUOT_EN
    output logic [W-1:0] quo,
`endif
    output logic [W:0]   rem
);
    localparam int CNT_W = $clog2(W);

    logic             busy_q;
    logic [CNT_W-1:0] cnt_q;
    logic [W-1:0]     rem_p0;
    logic [W-1:0]     quo_p0;
    logic [W-1:0]     dvs_p0;
    logic [W:0]       shifted;
    logic [W+1:0]     diff;
    logic             qbit;
    logic [W-1:0]     quo_nxt;

    always_comb begin
        shifted = {rem_p0, quo_p0[W-1]};
        diff    = {1'b0, shifted} - {2'b00, dvs_p0};
        qbit    = ~diff[W+1];
        rem     = qbit ? diff[W:0] : shifted;
        quo_nxt = {quo_p0[W-2:0], qbit};
        done    = busy_q && (cnt_q == CNT_W'(W - 1));
    end

`ifdef SEQ_ALU_QUOT_EN
    assign quo = quo_nxt;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (start) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
        end else if (done) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (busy_q) begin
            cnt_q  <= cnt_q + CNT_W'(1);
        end
    end

    // Stage p0: partial remainder, dividend/quotient shift register, divisor
    always_ff @(posedge clk) begin
        if (start) begin
            rem_p0 <= '0;
            quo_p0 <= dividend;
            dvs_p0 <= divisor;
        end else if (busy_q) begin
            rem_p0 <= rem[W-1:0];
            quo_p0 <= quo_nxt;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Sequential signed ALU: add/sub complete in one cycle, mul/rem iterate W cycles.
// Define SEQ_ALU_QUOT_EN to add the signed truncated quotient output for op=11.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int W = 3
) (
    input  logic     clk,
    input  logic     rst,
    seq_alu_if.slave bus
);
    localparam int RW    = 2 * W;
    localparam int CNT_W = $clog2(W);

    function automatic logic [W-1:0] mag(input logic signed [W-1:0] v);
        logic [W-1:0] u;
        u = v;
        return u[W-1] ? (~u + W'(1)) : u;
    endfunction

    function automatic logic signed [RW-1:0] apply_sign(input logic [RW-1:0] m, input logic neg);
        return neg ? -$signed(m) : $signed(m);
    endfunction

    state_e              state_q, state_nxt;
    logic [CNT_W-1:0]    cnt_q;
    logic                accept, last, mul_last;
    logic                div_start, div_done;
    logic [W:0]          div_rem;
    logic [W-1:0]        a_mag, b_mag;
    logic signed [RW-1:0] r_q;
    logic                err_q;

    op_e                 op_p0;
    logic signed [W-1:0] a_p0;
    logic                b_zero_p0, neg_p0;
    logic [RW-1:0]       mcand_p0, acc_p0, acc_nxt;
    logic [W-1:0]        mplier_p0;

    assign accept    = bus.in_valid && (state_q == S_IDLE);
    assign a_mag     = mag(bus.a);
    assign b_mag     = mag(bus.b);
    assign div_start = accept && (bus.op == OP_REM);
    assign mul_last  = (state_q == S_BUSY) && (cnt_q == CNT_W'(W - 1));
    assign last      = (op_p0 == OP_REM) ? div_done : mul_last;
    assign acc_nxt   = acc_p0 + (mplier_p0[0] ? mcand_p0 : '0);

`ifdef SEQ_ALU_QUOT_EN
    logic [W-1:0]      div_quo;
    logic [W:0]        quo_mag;
    logic signed [W:0] quot_q;

    assign quo_mag  = {1'b0, div_quo};
    assign bus.quot = quot_q;
`endif

    seq_alu_div #(.W(W)) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (a_mag),
        .divisor  (b_mag),
        .done     (div_done),
`ifdef SEQ_ALU_QUOT_EN
        .quo      (div_quo),
`endif
        .rem      (div_rem)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                if (accept) state_nxt = is_iterative(bus.op) ? S_BUSY : S_DONE;
            end
            S_BUSY: begin
                if (last) state_nxt = S_DONE;
            end
            S_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            r_q   <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= (state_q == S_BUSY && !last) ? cnt_q + CNT_W'(1) : '0;
            if (accept) begin
                err_q <= 1'b0;
                if (bus.op == OP_ADD) r_q <= RW'(bus.a) + RW'(bus.b);
                else if (bus.op == OP_SUB) r_q <= RW'(bus.a) - RW'(bus.b);
            end else if (last) begin
                if (op_p0 == OP_MUL) begin
                    r_q <= apply_sign(acc_nxt, neg_p0);
                end else begin
                    err_q <= b_zero_p0;
                    r_q   <= b_zero_p0 ? RW'(a_p0) : apply_sign(RW'(div_rem), a_p0[W-1]);
                end
            end
        end
    end

`ifdef SEQ_ALU_QUOT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quot_q <= '0;
        end else if (accept) begin
            quot_q <= '0;
        end else if (last && op_p0 == OP_REM && !b_zero_p0) begin
            quot_q <= neg_p0 ? -$signed(quo_mag) : $signed(quo_mag);
        end
    end
`endif

    // Stage p0: operands latched at accept, shift-add multiplier state
    always_ff @(posedge clk) begin
        if (accept) begin
            op_p0     <= bus.op;
            a_p0      <= bus.a;
            b_zero_p0 <= (bus.b == '0);
            neg_p0    <= bus.a[W-1] ^ bus.b[W-1];
            mcand_p0  <= RW'(a_mag);
            mplier_p0 <= b_mag;
            acc_p0    <= '0;
        end else if (state_q == S_BUSY) begin
            acc_p0    <= acc_nxt;
            mcand_p0  <= mcand_p0 << 1;
            mplier_p0 <= mplier_p0 >> 1;
        end
    end

    assign bus.r   = r_q;
    assign bus.err = err_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at W=3 plus a W=8 regression against native SV arithmetic.
module tb_seq_alu;
    import seq_alu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    seq_alu_if #(.W(3)) b3 ();
    seq_alu_if #(.W(8)) b8 ();

    seq_alu #(.W(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));
    seq_alu #(.W(8)) dut8 (.clk(clk), .rst(rst), .bus(b8));

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic release3();
        b3.out_ready = 1'b1;
        @(posedge clk); #1;
        b3.out_ready = 1'b0;
    endtask

    task automatic run3(input int ai, input int bi, input op_e op, output int lat);
        int guard = 0;
        while (!b3.in_ready && guard < 20) begin @(posedge clk); #1; guard++; end
        b3.a = ai[2:0]; b3.b = bi[2:0]; b3.op = op; b3.in_valid = 1'b1;
        @(posedge clk); #1;
        b3.in_valid = 1'b0; b3.a = ~b3.a; b3.b = ~b3.b; b3.op = OP_ADD;
        lat = 1;
        while (!b3.out_valid && lat < 30) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic op3(input string tag, input int ai, input int bi, input op_e op,
                       input int exp_r, input int exp_err, input int exp_lat);
        int lat;
        run3(ai, bi, op, lat);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_r"}, b3.r, exp_r);
        check({tag, "_err"}, b3.err, exp_err);
`ifdef SEQ_ALU_QUOT_EN
        check({tag, "_quot"}, b3.quot, (op == OP_REM && bi != 0) ? ai / bi : 0);
`endif
        release3();
        check({tag, "_idle"}, {b3.in_ready, b3.out_valid}, 2);
    endtask

    function automatic int model8(input int ai, input int bi, input op_e op);
        case (op)
            OP_ADD:  return ai + bi;
            OP_SUB:  return ai - bi;
            OP_MUL:  return ai * bi;
            default: return (bi == 0) ? ai : ai % bi;
        endcase
    endfunction

    task automatic op8(input int ai, input int bi, input op_e op);
        int    lat = 1;
        int    guard = 0;
        string tag;
        tag = $sformatf("w8_%0d_%0d_op%0d", ai, bi, op);
        while (!b8.in_ready && guard < 20) begin @(posedge clk); #1; guard++; end
        b8.a = ai[7:0]; b8.b = bi[7:0]; b8.op = op; b8.in_valid = 1'b1;
        @(posedge clk); #1;
        b8.in_valid = 1'b0; b8.a = 8'h5a; b8.b = 8'ha5; b8.op = OP_SUB;
        while (!b8.out_valid && lat < 30) begin @(posedge clk); #1; lat++; end
        check({tag, "_lat"}, lat, is_iterative(op) ? 9 : 1);
        check({tag, "_r"}, b8.r, model8(ai, bi, op));
        check({tag, "_err"}, b8.err, (op == OP_REM && bi == 0) ? 1 : 0);
`ifdef SEQ_ALU_QUOT_EN
        check({tag, "_quot"}, b8.quot, (op == OP_REM && bi != 0) ? ai / bi : 0);
`endif
        b8.out_ready = 1'b1;
        @(posedge clk); #1;
        b8.out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        rst = 1'b1;
        b3.in_valid = 1'b0; b3.a = '0; b3.b = '0; b3.op = OP_ADD; b3.out_ready = 1'b0;
        b8.in_valid = 1'b0; b8.a = '0; b8.b = '0; b8.op = OP_ADD; b8.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", b3.in_ready, 1);
        check("rst_out_valid", b3.out_valid, 0);
        check("rst_r", b3.r, 0);
        check("rst_err", b3.err, 0);
        rst = 1'b0;

        op3("add_3_3",   3,  3, OP_ADD,   6, 0, 1);
        op3("sub_m4_3", -4,  3, OP_SUB,  -7, 0, 1);
        op3("add_m4_m4",-4, -4, OP_ADD,  -8, 0, 1);
        op3("sub_3_m4",  3, -4, OP_SUB,   7, 0, 1);
        op3("mul_m4_m4",-4, -4, OP_MUL,  16, 0, 4);
        op3("mul_3_m4",  3, -4, OP_MUL, -12, 0, 4);
        op3("rem_m3_2", -3,  2, OP_REM,  -1, 0, 4);
        op3("rem_3_m2",  3, -2, OP_REM,   1, 0, 4);
        op3("rem_2_0",   2,  0, OP_REM,   2, 1, 4);
        op3("rem_m4_m1",-4, -1, OP_REM,   0, 0, 4);

        // Result held in DONE while the consumer stalls; new requests ignored
        run3(1, 2, OP_ADD, lat);
        check("stall_lat", lat, 1);
        for (int i = 0; i < 5; i++) begin
            b3.in_valid = (i % 2 == 0); b3.a = -1; b3.b = -1; b3.op = OP_MUL;
            @(posedge clk); #1;
            check($sformatf("stall%0d_r", i), b3.r, 3);
            check($sformatf("stall%0d_flags", i), {b3.out_valid, b3.in_ready, b3.err}, 3'b100);
        end
        b3.in_valid = 1'b0;
        release3();
        check("stall_release", {b3.in_ready, b3.out_valid}, 2);
        repeat (2) @(posedge clk);
        #1;
        check("stall_no_launch", {b3.in_ready, b3.out_valid}, 2);

        // Reset in the middle of a multiply discards it
        b3.a = 3; b3.b = 3; b3.op = OP_MUL; b3.in_valid = 1'b1;
        @(posedge clk); #1;
        b3.in_valid = 1'b0;
        @(posedge clk); #1;
        check("busy_flags", {b3.in_ready, b3.out_valid}, 0);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", b3.out_valid, 0);
        check("midrst_r", b3.r, 0);
        check("midrst_in_ready", b3.in_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("midrst_discard", b3.out_valid, 0);
        op3("post_rst_add", 1, 1, OP_ADD, 2, 0, 1);

        op8(-128, -128, OP_MUL);
        op8( 127, -128, OP_MUL);
        op8(-128,   -1, OP_REM);
        op8(-128,    0, OP_REM);
        op8(-128,    3, OP_REM);
        op8(-128,  127, OP_SUB);
        op8(-128, -128, OP_ADD);
        for (int i = 0; i < 24; i++) begin
            int ai, bi;
            ai = int'($urandom_range(255)) - 128;
            bi = int'($urandom_range(255)) - 128;
            if (i % 7 == 0) ai = -128;
            if (i % 5 == 0) bi = 0;
            op8(ai, bi, op_e'(i % 4));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
